// File: rtl/emu_time_ctrl_if.sv
// Host-side command channel for emu_time_ctrl.
// A command transfers on a cycle where cmd_valid && cmd_ready; cmd_op/cmd_data are sampled only then.
interface emu_time_ctrl_if #(
  parameter int TIME_WIDTH = 64
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [1:0]                   cmd_op;
  logic signed [TIME_WIDTH-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/emu_time_ctrl.sv
// Run-control sequencer owning one dt lane into the min-reducing time manager.
// Optional macro EMU_TIME_CTRL_ABORT_EN adds cmd_abort to cancel UNTIL/STEPS.
module emu_time_ctrl #(
  parameter int width      = 32,
  parameter int time_width = 64,
  parameter int cnt_width  = 32
) (
  input  logic                         emu_clk,
  input  logic                         emu_rst,
  emu_time_ctrl_if.slave               cmd,
`ifdef EMU_TIME_CTRL_ABORT_EN
  input  logic                         cmd_abort,
`endif
  input  logic signed [time_width-1:0] emu_time,
  input  logic signed [width-1:0]      emu_dt,
  output logic signed [width-1:0]      dt_req,
  output logic                         emu_stall,
  output logic                         busy,
  output logic                         done,
  output logic [cnt_width-1:0]         steps_left,
  output logic [2:0]                   state_probe
);

  typedef enum logic [2:0] {
    S_STALL = 3'd0,
    S_RUN   = 3'd1,
    S_UNTIL = 3'd2,
    S_STEPS = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] OP_STALL = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_UNTIL = 2'd2;
  localparam logic [1:0] OP_STEPS = 2'd3;

  localparam logic signed [width-1:0]    DT_MAX   = {1'b0, {(width-1){1'b1}}};
  localparam logic signed [time_width:0] DT_MAX_W = {{(time_width-width+2){1'b0}}, {(width-1){1'b1}}};

  state_t                       r_state, w_state_next;
  logic signed [time_width-1:0] r_target, w_target_next;
  logic [cnt_width-1:0]         r_cnt, w_cnt_next;
  logic                         r_done, w_done_next;
  logic                         w_accept;
  logic signed [time_width:0]   w_diff;
  logic signed [width-1:0]      w_clamp;

  assign w_accept = cmd.cmd_valid && cmd.cmd_ready;

  // Extra bit keeps target - emu_time from wrapping at the extremes of the time range.
  assign w_diff = {r_target[time_width-1], r_target} - {emu_time[time_width-1], emu_time};

  always_comb begin
    w_clamp = '0;
    if (w_diff <= 0)
      w_clamp = '0;
    else if (w_diff > DT_MAX_W)
      w_clamp = DT_MAX;
    else
      w_clamp = w_diff[width-1:0];
  end

  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      r_state  <= S_STALL;
      r_target <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_target <= w_target_next;
      r_cnt    <= w_cnt_next;
      r_done   <= w_done_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_target_next = r_target;
    w_cnt_next    = r_cnt;
    w_done_next   = 1'b0;
    case (r_state)
      S_STALL, S_RUN, S_DONE: begin
        if (w_accept) begin
          case (cmd.cmd_op)
            OP_STALL: w_state_next = S_STALL;
            OP_RUN:   w_state_next = S_RUN;
            OP_UNTIL: begin
              w_target_next = cmd.cmd_data;
              if (cmd.cmd_data > emu_time) begin
                w_state_next = S_UNTIL;
              end else begin
                w_state_next = S_DONE;
                w_done_next  = 1'b1;
              end
            end
            default: begin
              w_cnt_next = cmd.cmd_data[cnt_width-1:0];
              if (cmd.cmd_data[cnt_width-1:0] == '0) begin
                w_state_next = S_DONE;
                w_done_next  = 1'b1;
              end else begin
                w_state_next = S_STEPS;
              end
            end
          endcase
        end
      end
      S_UNTIL: begin
        // Overshoot should not happen with a min tree; finish anyway rather than hang.
        if (emu_time >= r_target) begin
          w_state_next = S_DONE;
          w_done_next  = 1'b1;
        end
      end
      S_STEPS: begin
        if (emu_dt != '0) begin
          w_cnt_next = r_cnt - 1'b1;
          if (r_cnt == {{(cnt_width-1){1'b0}}, 1'b1}) begin
            w_state_next = S_DONE;
            w_done_next  = 1'b1;
          end
        end
      end
      default: w_state_next = S_STALL;
    endcase
`ifdef EMU_TIME_CTRL_ABORT_EN
    if (cmd_abort && (r_state == S_UNTIL || r_state == S_STEPS)) begin
      w_state_next = S_STALL;
      w_cnt_next   = '0;
      w_done_next  = 1'b0;
    end
`endif
  end

  // dt_req depends only on registered state, target and emu_time, never on emu_dt.
  always_comb begin
    dt_req        = '0;
    emu_stall     = 1'b0;
    busy          = 1'b0;
    cmd.cmd_ready = 1'b0;
    steps_left    = '0;
    case (r_state)
      S_STALL, S_DONE: begin
        emu_stall     = 1'b1;
        cmd.cmd_ready = 1'b1;
      end
      S_RUN: begin
        dt_req        = DT_MAX;
        cmd.cmd_ready = 1'b1;
      end
      S_UNTIL: begin
        dt_req = w_clamp;
        busy   = 1'b1;
      end
      S_STEPS: begin
        dt_req     = DT_MAX;
        busy       = 1'b1;
        steps_left = r_cnt;
      end
      default: emu_stall = 1'b1;
    endcase
  end

  assign done        = r_done;
  assign state_probe = r_state;

endmodule

// File: tb/tb_emu_time_ctrl.sv
// Directed table-driven bench for emu_time_ctrl; emu_time/emu_dt are driven by hand
// to stand in for the time manager.
module tb_emu_time_ctrl;

  localparam logic [31:0] DTM = 32'h7FFF_FFFF;

  typedef struct {
    logic        rst;
    logic        v;
    logic [1:0]  op;
    logic [63:0] data;
    logic [63:0] t;
    logic [31:0] dt;
    logic [2:0]  st;
    logic [31:0] dtr;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] sl;
    logic        rdy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] emu_time = '0;
  logic [31:0] emu_dt = '0;
  logic [31:0] dt_req;
  logic        emu_stall, busy, done;
  logic [31:0] steps_left;
  logic [2:0]  state_probe;
`ifdef EMU_TIME_CTRL_ABORT_EN
  logic        cmd_abort = 1'b0;
`endif

  int n_vec  = 0;
  int n_fail = 0;
  vec_t vecs[$];

  emu_time_ctrl_if #(.TIME_WIDTH(64)) cmd_if ();

  emu_time_ctrl dut (
    .emu_clk     (clk),
    .emu_rst     (rst),
    .cmd         (cmd_if),
`ifdef EMU_TIME_CTRL_ABORT_EN
    .cmd_abort   (cmd_abort),
`endif
    .emu_time    (emu_time),
    .emu_dt      (emu_dt),
    .dt_req      (dt_req),
    .emu_stall   (emu_stall),
    .busy        (busy),
    .done        (done),
    .steps_left  (steps_left),
    .state_probe (state_probe)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic v, logic [1:0] op, logic [63:0] data,
                              logic [63:0] t, logic [31:0] dt, logic [2:0] st,
                              logic [31:0] dtr, logic stall, logic bsy, logic dn,
                              logic [31:0] sl, logic rdy);
    vec_t x;
    x.rst = r; x.v = v; x.op = op; x.data = data; x.t = t; x.dt = dt;
    x.st = st; x.dtr = dtr; x.stall = stall; x.busy = bsy; x.done = dn;
    x.sl = sl; x.rdy = rdy;
    return x;
  endfunction

  task automatic cmp(string n, string f, logic [31:0] got, logic [31:0] exp);
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s got=%0h exp=%0h", n, f, got, exp);
    end
  endtask

  task automatic apply(string n, vec_t e);
    rst              = e.rst;
    cmd_if.cmd_valid = e.v;
    cmd_if.cmd_op    = e.op;
    cmd_if.cmd_data  = e.data;
    emu_time         = e.t;
    emu_dt           = e.dt;
    @(posedge clk);
    #1;
    n_vec++;
    cmp(n, "state", {29'd0, state_probe}, {29'd0, e.st});
    cmp(n, "dt_req", dt_req, e.dtr);
    cmp(n, "stall", {31'd0, emu_stall}, {31'd0, e.stall});
    cmp(n, "busy", {31'd0, busy}, {31'd0, e.busy});
    cmp(n, "done", {31'd0, done}, {31'd0, e.done});
    cmp(n, "steps_left", steps_left, e.sl);
    cmp(n, "ready", {31'd0, cmd_if.cmd_ready}, {31'd0, e.rdy});
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'd0;
    cmd_if.cmd_data  = '0;

    apply("reset0", mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    apply("reset1", mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    for (int i = 0; i < 10; i++)
      apply($sformatf("idle%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));

    // rst v op data t dt | st dtr stall busy done sl rdy
    vecs.push_back(mk(0, 1, 1, 0,   0,   0,   1, DTM, 0, 0, 0, 0, 1));  // RUN
    vecs.push_back(mk(0, 0, 0, 0,   0,   DTM, 1, DTM, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0,   0,   0,   0, 0,   1, 0, 0, 0, 1));  // STALL
    vecs.push_back(mk(0, 1, 2, 250, 100, 0,   2, 150, 0, 1, 0, 0, 0));  // UNTIL 250 @100
    vecs.push_back(mk(0, 0, 0, 0,   100, 150, 2, 150, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   250, 0,   4, 0,   1, 0, 1, 0, 1));  // reached target
    vecs.push_back(mk(0, 0, 0, 0,   250, 0,   4, 0,   1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 2, 50,  100, 0,   4, 0,   1, 0, 1, 0, 1));  // UNTIL in the past
    vecs.push_back(mk(0, 0, 0, 0,   100, 0,   4, 0,   1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 3, 64'h1_0000_0000, 0, 0, 4, 0, 1, 0, 1, 0, 1));  // STEPS 0 (low bits)
    vecs.push_back(mk(0, 0, 0, 0,   0,   0,   4, 0,   1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 3, 4,   0,   0,   3, DTM, 0, 1, 0, 4, 0));  // STEPS 4
    vecs.push_back(mk(0, 0, 0, 0,   0,   DTM, 3, DTM, 0, 1, 0, 3, 0));
    vecs.push_back(mk(0, 1, 0, 0,   0,   0,   3, DTM, 0, 1, 0, 3, 0));  // stalled tick, STALL ignored
    vecs.push_back(mk(0, 0, 0, 0,   0,   5,   3, DTM, 0, 1, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0,   0,   3, DTM, 0, 1, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0,   7,   3, DTM, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0,   1,   4, 0,   1, 0, 1, 0, 1));  // last step
    vecs.push_back(mk(0, 0, 0, 0,   0,   0,   4, 0,   1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 2, 64'h100_0000_0000, 0, 0, 2, DTM, 0, 1, 0, 0, 0));  // clamp high
    vecs.push_back(mk(0, 0, 0, 0, 64'h100_0000_0000 - 10, 0, 2, 10, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 64'h100_0000_0000 + 5, 0, 4, 0, 1, 0, 1, 0, 1));  // overshoot
    vecs.push_back(mk(0, 1, 1, 0,   0,   0,   1, DTM, 0, 0, 0, 0, 1));  // RUN from DONE
    vecs.push_back(mk(1, 0, 0, 0,   0,   0,   0, 0,   1, 0, 0, 0, 1));  // reset while running

    for (int i = 0; i < vecs.size(); i++)
      apply($sformatf("vec%0d", i), vecs[i]);

    // Reset mid-STEPS discards the run without a done pulse.
    apply("rs_go",  mk(0, 1, 3, 5, 0, 0, 3, DTM, 0, 1, 0, 5, 0));
    apply("rs_t1",  mk(0, 0, 0, 0, 0, 1, 3, DTM, 0, 1, 0, 4, 0));
    apply("rs_t2",  mk(0, 0, 0, 0, 0, 1, 3, DTM, 0, 1, 0, 3, 0));
    apply("rs_t3",  mk(0, 0, 0, 0, 0, 1, 3, DTM, 0, 1, 0, 2, 0));
    apply("rs_rst", mk(1, 0, 0, 0, 0, 1, 0, 0,   1, 0, 0, 0, 1));
    apply("rs_aft", mk(0, 0, 0, 0, 0, 1, 0, 0,   1, 0, 0, 0, 1));
    apply("rs_aft2", mk(0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 1));

`ifdef EMU_TIME_CTRL_ABORT_EN
    apply("ab_go", mk(0, 1, 2, 1000, 0, 0, 2, 1000, 0, 1, 0, 0, 0));
    cmd_abort = 1'b1;
    apply("ab_hit", mk(0, 0, 0, 0, 10, 0, 0, 0, 1, 0, 0, 0, 1));
    cmd_abort = 1'b1;
    apply("ab_ign", mk(0, 1, 1, 0, 10, 0, 1, DTM, 0, 0, 0, 0, 1));
    cmd_abort = 1'b0;
    apply("ab_stl", mk(0, 1, 0, 0, 10, 0, 0, 0, 1, 0, 0, 0, 1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
